exec_issue_pipeline: RTL and testbench

Parametrised, pipelined successor to the single-issue execution FSM. Accepts decoded instructions with a valid/ready handshake, issues registered operands to the ALU, and tracks up to DEPTH in-flight destinations in an in-order queue. Retires ALU results to RAM write-back, resolves branches with squash of younger in-flight work, and stalls issue on read-after-write hazards against pending destinations. Sits between the instruction decode unit and the ALU/RAM write port of a Theia core.

---
 rtl/exec_issue_pipeline_pkg.sv | 27 ++
 rtl/exec_issue_pipeline_dest_queue.sv | 86 ++++++++
 rtl/exec_issue_pipeline.sv | 166 ++++++++++++++++
 tb/tb_exec_issue_pipeline.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_issue_pipeline_pkg.sv
// Shared types and opcode helpers for the pipelined execution/issue unit.
// Opcode class lives in the top nibble; an all-zero opcode is a NOP.
package exec_issue_pipeline_pkg;

    typedef enum logic [1:0] {
        ST_AFTER_RESET = 2'd0,
        ST_RUN         = 2'd1,
        ST_FLUSH       = 2'd2
    } exe_state_t;

    localparam logic [15:0] OP_NOP       = 16'h0000;
    localparam logic [3:0]  BRANCH_CLASS = 4'hB;

    function automatic logic op_is_branch(input logic [3:0] cls);
        return cls == BRANCH_CLASS;
    endfunction

    function automatic logic op_writes(input logic is_nop, input logic [3:0] cls);
        return !is_nop && !op_is_branch(cls);
    endfunction

    // LSB position of channel ch in a packed row of width-bit channels
    function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/exec_issue_pipeline_dest_queue.sv
// In-order queue of in-flight destinations with per-entry squash bits
// and a parallel compare of two source addresses against live writers.
module exec_dest_queue
    import exec_issue_pipeline_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int OP_W   = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [OP_W-1:0]   i_push_op,
    input  logic [ADDR_W-1:0] i_push_dest,
    input  logic              i_pop,
    input  logic              i_squash,
    input  logic [ADDR_W-1:0] i_cmp_a,
    input  logic [ADDR_W-1:0] i_cmp_b,
    output logic [OP_W-1:0]   o_head_op,
    output logic [ADDR_W-1:0] o_head_dest,
    output logic              o_head_squash,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_hit
);

    logic [OP_W-1:0]   r_op   [DEPTH];
    logic [ADDR_W-1:0] r_dest [DEPTH];
    logic [DEPTH-1:0]  r_sq;
    logic [PTR_W-1:0]  r_rd;
    logic [PTR_W-1:0]  r_wr;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_off [DEPTH];
    logic [DEPTH-1:0]  w_valid;
    logic [DEPTH-1:0]  w_hit;

    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & !o_full;
    assign w_pop   = i_pop & !o_empty;

    // Entry g is live when its distance from the head is below the count
    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        assign w_off[g]   = PTR_W'(g) - r_rd;
        assign w_valid[g] = ({1'b0, w_off[g]} < r_cnt);
        assign w_hit[g]   = w_valid[g] & !r_sq[g]
                          & op_writes(r_op[g] == '0, r_op[g][OP_W-1 -: 4])
                          & ((r_dest[g] == i_cmp_a) | (r_dest[g] == i_cmp_b));
    end

    assign o_hit         = |w_hit;
    assign o_head_op     = r_op[r_rd];
    assign o_head_dest   = r_dest[r_rd];
    assign o_head_squash = r_sq[r_rd];
    assign o_count       = r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_sq  <= '0;
        end else begin
            if (i_squash) begin
                r_sq <= '1;
            end
            if (w_push) begin
                r_op[r_wr]   <= i_push_op;
                r_dest[r_wr] <= i_push_dest;
                r_sq[r_wr]   <= 1'b0;
                r_wr         <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/exec_issue_pipeline.sv
// Pipelined issue/retire unit: handshakes decoded ops to the ALU, tracks
// in-flight destinations, writes results back and resolves branches.
module exec_issue_pipeline
    import exec_issue_pipeline_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHANNELS   = 3,
    parameter int ADDR_W     = 16,
    parameter int OP_W       = 16,
    parameter int ROM_ADDR_W = 16,
    parameter int DEPTH      = 4,
    localparam int DW        = CHANNELS * WIDTH,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iDecodeDone,
    output logic                  oExeReady,
    input  logic [OP_W-1:0]       iOperation,
    input  logic [DW-1:0]         iSource0,
    input  logic [DW-1:0]         iSource1,
    input  logic [ADDR_W-1:0]     iDestination,
    input  logic [ADDR_W-1:0]     iSrc0Addr,
    input  logic [ADDR_W-1:0]     iSrc1Addr,
    output logic                  oTriggerALU,
    output logic [OP_W-1:0]       oALUOperation,
    output logic [DW-1:0]         oALUSrcA,
    output logic [DW-1:0]         oALUSrcB,
    input  logic [DW-1:0]         iALUResult,
    input  logic                  iALUOutputReady,
    input  logic                  iBranchTaken,
    input  logic                  iBranchNotTaken,
    output logic                  oJumpFlag,
    output logic [ROM_ADDR_W-1:0] oJumpIp,
    output logic                  oRAMWriteEnable,
    output logic [ADDR_W-1:0]     oRAMWriteAddress,
    output logic [DW-1:0]         oRAMWriteData,
    output logic                  oBusy,
    output logic [CNT_W-1:0]      oPending,
    output logic [ADDR_W-1:0]     oLastDestination,
    output logic                  oUnderflow
);

    exe_state_t            r_state;
    logic                  r_trig;
    logic [OP_W-1:0]       r_op;
    logic [DW-1:0]         r_srca;
    logic [DW-1:0]         r_srcb;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_waddr;
    logic [DW-1:0]         r_wdata;
    logic                  r_jump;
    logic [ROM_ADDR_W-1:0] r_jip;
    logic                  r_uf;

    logic [OP_W-1:0]       w_head_op;
    logic [ADDR_W-1:0]     w_head_dest;
    logic                  w_head_sq;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_qhit;
    logic                  w_hazard;
    logic                  w_accept;
    logic                  w_retire;
    logic                  w_live;
    logic                  w_write;
    logic                  w_jump;

    exec_dest_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .OP_W   (OP_W)
    ) u_queue (
        .i_clk         (Clock),
        .i_rst         (Reset),
        .i_push        (w_accept),
        .i_push_op     (iOperation),
        .i_push_dest   (iDestination),
        .i_pop         (w_retire),
        .i_squash      (w_jump),
        .i_cmp_a       (iSrc0Addr),
        .i_cmp_b       (iSrc1Addr),
        .o_head_op     (w_head_op),
        .o_head_dest   (w_head_dest),
        .o_head_squash (w_head_sq),
        .o_count       (w_count),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_hit         (w_qhit)
    );

    // A write already on the RAM port still counts as pending for one cycle
    assign w_hazard = w_qhit | (r_we & ((iSrc0Addr == r_waddr) | (iSrc1Addr == r_waddr)));
    assign oExeReady = (r_state == ST_RUN) & !w_full & !w_hazard & !iBranchTaken;
    assign w_accept  = iDecodeDone & oExeReady;
    assign w_retire  = iALUOutputReady & !w_empty;
    assign w_live    = w_retire & !w_head_sq & (r_state == ST_RUN);
    assign w_write   = w_live & (w_head_op != OP_W'(OP_NOP))
                     & !iBranchTaken & !iBranchNotTaken;
    assign w_jump    = w_live & iBranchTaken;

    assign oTriggerALU      = r_trig;
    assign oALUOperation    = r_op;
    assign oALUSrcA         = r_srca;
    assign oALUSrcB         = r_srcb;
    assign oRAMWriteEnable  = r_we;
    assign oRAMWriteAddress = r_waddr;
    assign oRAMWriteData    = r_wdata;
    assign oLastDestination = r_waddr;
    assign oJumpFlag        = r_jump;
    assign oJumpIp          = r_jip;
    assign oUnderflow       = r_uf;
    assign oPending         = w_count;
    assign oBusy            = (w_count != '0) | (r_state != ST_RUN);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_AFTER_RESET;
            r_trig  <= 1'b0;
            r_op    <= '0;
            r_srca  <= '0;
            r_srcb  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_jump  <= 1'b0;
            r_jip   <= '0;
            r_uf    <= 1'b0;
        end else begin
            r_trig <= w_accept;
            if (w_accept) begin
                r_op   <= iOperation;
                r_srca <= iSource1;
                r_srcb <= iSource0;
            end
            r_we <= w_write;
            if (w_write) begin
                r_waddr <= w_head_dest;
                r_wdata <= iALUResult;
            end
            r_jump <= w_jump;
            if (w_jump) begin
                r_jip <= ROM_ADDR_W'(w_head_dest);
            end
            if (iALUOutputReady & w_empty) begin
                r_uf <= 1'b1;
            end
            unique case (r_state)
                ST_AFTER_RESET: r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_jump && (w_count > CNT_W'(1))) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_empty) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_AFTER_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_issue_pipeline.sv
// Directed and random stimulus for exec_issue_pipeline, checked against
// a queue-based reference model of issue, retire and branch rules.
module tb_exec_issue_pipeline;
    import exec_issue_pipeline_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iDecodeDone;
    logic        oExeReady;
    logic [15:0] iOperation;
    logic [95:0] iSource0, iSource1;
    logic [15:0] iDestination, iSrc0Addr, iSrc1Addr;
    logic        oTriggerALU;
    logic [15:0] oALUOperation;
    logic [95:0] oALUSrcA, oALUSrcB;
    logic [95:0] iALUResult;
    logic        iALUOutputReady, iBranchTaken, iBranchNotTaken;
    logic        oJumpFlag;
    logic [15:0] oJumpIp;
    logic        oRAMWriteEnable;
    logic [15:0] oRAMWriteAddress;
    logic [95:0] oRAMWriteData;
    logic        oBusy;
    logic [2:0]  oPending;
    logic [15:0] oLastDestination;
    logic        oUnderflow;

    exec_issue_pipeline dut (
        .Clock(Clock), .Reset(Reset), .iDecodeDone(iDecodeDone), .oExeReady(oExeReady),
        .iOperation(iOperation), .iSource0(iSource0), .iSource1(iSource1),
        .iDestination(iDestination), .iSrc0Addr(iSrc0Addr), .iSrc1Addr(iSrc1Addr),
        .oTriggerALU(oTriggerALU), .oALUOperation(oALUOperation),
        .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB), .iALUResult(iALUResult),
        .iALUOutputReady(iALUOutputReady), .iBranchTaken(iBranchTaken),
        .iBranchNotTaken(iBranchNotTaken), .oJumpFlag(oJumpFlag), .oJumpIp(oJumpIp),
        .oRAMWriteEnable(oRAMWriteEnable), .oRAMWriteAddress(oRAMWriteAddress),
        .oRAMWriteData(oRAMWriteData), .oBusy(oBusy), .oPending(oPending),
        .oLastDestination(oLastDestination), .oUnderflow(oUnderflow)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] op;
        logic [15:0] dest;
        bit          sq;
    } ent_t;

    ent_t        q[$];
    int          m_st;
    bit          m_trig, m_we, m_jump, m_uf;
    logic [15:0] m_op, m_waddr, m_jip, m_last;
    logic [95:0] m_a, m_b, m_wdata;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic bit writes(input logic [15:0] op);
        return op != 16'h0 && op[15:12] != 4'hB;
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] row(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        logic [95:0] r;
        r = '0;
        r[chan_lsb(2, 32) +: 32] = x;
        r[chan_lsb(1, 32) +: 32] = y;
        r[chan_lsb(0, 32) +: 32] = z;
        return r;
    endfunction

    task automatic drive(input bit dv, input logic [15:0] op, input logic [15:0] dest,
                         input logic [15:0] s0a, input logic [15:0] s1a, input bit rdy,
                         input bit tk, input bit ntk, input logic [95:0] res);
        iDecodeDone     = dv;
        iOperation      = op;
        iDestination    = dest;
        iSrc0Addr       = s0a;
        iSrc1Addr       = s1a;
        iSource0        = {$urandom, $urandom, $urandom};
        iSource1        = {$urandom, $urandom, $urandom};
        iALUOutputReady = rdy;
        iBranchTaken    = tk;
        iBranchNotTaken = ntk;
        iALUResult      = res;
    endtask

    task automatic idle();
        drive(0, 16'h0, 16'h0, 16'h80, 16'h81, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        q.delete();
        m_st = 0; m_trig = 0; m_we = 0; m_jump = 0; m_uf = 0;
        m_op = '0; m_waddr = '0; m_jip = '0; m_last = '0;
        m_a = '0; m_b = '0; m_wdata = '0;
        chk("rst_trig", oTriggerALU, 0);
        chk("rst_we", oRAMWriteEnable, 0);
        chk("rst_jump", oJumpFlag, 0);
        chk("rst_uf", oUnderflow, 0);
        chk("rst_pend", oPending, 0);
        chk("rst_srca", oALUSrcA, 0);
        chk("rst_wdata", oRAMWriteData, 0);
        chk("rst_jip", oJumpIp, 0);
    endtask

    // One clock: check combinational outputs, advance model, check registers
    task automatic step();
        bit haz, rdy, acc, ret;
        int pre;
        ent_t h;
        #1;
        haz = 0;
        foreach (q[i])
            if (!q[i].sq && writes(q[i].op) &&
                (q[i].dest == iSrc0Addr || q[i].dest == iSrc1Addr)) haz = 1;
        if (m_we && (m_waddr == iSrc0Addr || m_waddr == iSrc1Addr)) haz = 1;
        rdy = (m_st == 1) && q.size() < 4 && !haz && !iBranchTaken;
        chk("ready", oExeReady, rdy);
        chk("pending", oPending, q.size());
        chk("busy", oBusy, q.size() != 0 || m_st != 1);
        acc = iDecodeDone && rdy;
        ret = iALUOutputReady && q.size() > 0;
        pre = q.size();
        if (iALUOutputReady && pre == 0) m_uf = 1;
        m_we = 0;
        m_jump = 0;
        if (m_st == 0) m_st = 1;
        else if (m_st == 2 && pre == 0) m_st = 1;
        if (ret) begin
            h = q.pop_front();
            if (m_st == 1 && !h.sq) begin
                if (iBranchTaken) begin
                    m_jump = 1;
                    m_jip = h.dest;
                    foreach (q[i]) q[i].sq = 1;
                    if (q.size() > 0) m_st = 2;
                end else if (!iBranchNotTaken && h.op != 16'h0) begin
                    m_we = 1;
                    m_waddr = h.dest;
                    m_last = h.dest;
                    m_wdata = iALUResult;
                end
            end
        end
        m_trig = acc;
        if (acc) begin
            q.push_back('{iOperation, iDestination, 1'b0});
            m_op = iOperation;
            m_a = iSource1;
            m_b = iSource0;
        end
        @(posedge Clock);
        #1;
        chk("trig", oTriggerALU, m_trig);
        if (m_trig) begin
            chk("aluop", oALUOperation, m_op);
            chk("srca", oALUSrcA, m_a);
            chk("srcb", oALUSrcB, m_b);
        end
        chk("we", oRAMWriteEnable, m_we);
        if (m_we) begin
            chk("waddr", oRAMWriteAddress, m_waddr);
            chk("wdata", oRAMWriteData, m_wdata);
        end
        chk("lastdst", oLastDestination, m_last);
        chk("jump", oJumpFlag, m_jump);
        if (m_jump) chk("jip", oJumpIp, m_jip);
        chk("uf", oUnderflow, m_uf);
    endtask

    initial begin
        logic [15:0] op;
        int r;
        Reset = 1'b1;
        idle();
        do_reset();
        step();

        // single ADD round trip
        drive(1, 16'h1001, 16'h10, 16'h80, 16'h81, 0, 0, 0, '0);
        step();
        chk("add_trig", oTriggerALU, 1);
        idle();
        step();
        drive(0, 16'h0, 16'h0, 16'h80, 16'h81, 1, 0, 0, row(1, 2, 3));
        step();
        chk("add_waddr", oRAMWriteAddress, 16'h10);
        chk("add_wdata", oRAMWriteData, row(1, 2, 3));
        chk("add_pend", oPending, 0);

        // fill the queue with the ALU stalled
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'h1002, 16'(16'h21 + i), 16'h80, 16'h81, 0, 0, 0, '0);
            step();
        end
        drive(1, 16'h1002, 16'h25, 16'h80, 16'h81, 0, 0, 0, '0);
        step();
        chk("full_trig", oTriggerALU, 0);
        chk("full_pend", oPending, 4);
        chk("full_busy", oBusy, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 16'h0, 16'h0, 16'h80, 16'h81, 1, 0, 0, row(i, i, i));
            step();
        end

        // RAW hazard on 0x20
        drive(1, 16'h1003, 16'h20, 16'h80, 16'h81, 0, 0, 0, '0);
        step();
        drive(1, 16'h1004, 16'h30, 16'h20, 16'h81, 0, 0, 0, '0);
        step();
        step();
        chk("haz_stall", oTriggerALU, 0);
        drive(1, 16'h1004, 16'h30, 16'h20, 16'h81, 1, 0, 0, row(7, 7, 7));
        step();
        chk("haz_wr", oRAMWriteAddress, 16'h20);
        drive(1, 16'h1004, 16'h30, 16'h20, 16'h81, 0, 0, 0, '0);
        step();
        chk("haz_hold", oTriggerALU, 0);
        step();
        chk("haz_go", oTriggerALU, 1);
        drive(0, 16'h0, 16'h0, 16'h80, 16'h81, 1, 0, 0, row(8, 8, 8));
        step();

        // taken branch squashes two younger entries
        drive(1, 16'hB000, 16'h40, 16'h80, 16'h81, 0, 0, 0, '0);
        step();
        drive(1, 16'h1005, 16'h41, 16'h80, 16'h81, 0, 0, 0, '0);
        step();
        drive(1, 16'h1006, 16'h42, 16'h80, 16'h81, 0, 0, 0, '0);
        step();
        drive(0, 16'h0, 16'h0, 16'h80, 16'h81, 1, 1, 0, '0);
        step();
        chk("br_jump", oJumpFlag, 1);
        chk("br_ip", oJumpIp, 16'h40);
        drive(0, 16'h0, 16'h0, 16'h80, 16'h81, 1, 0, 0, row(9, 9, 9));
        step();
        step();
        chk("br_nowr", oRAMWriteEnable, 0);
        idle();
        step();
        step();
        chk("br_idle", oBusy, 0);

        // NOP and not-taken retires write nothing
        drive(1, 16'h0000, 16'h50, 16'h80, 16'h81, 0, 0, 0, '0);
        step();
        drive(1, 16'h1007, 16'h51, 16'h80, 16'h81, 0, 0, 0, '0);
        step();
        drive(0, 16'h0, 16'h0, 16'h80, 16'h81, 1, 0, 0, row(5, 5, 5));
        step();
        drive(0, 16'h0, 16'h0, 16'h80, 16'h81, 1, 0, 1, row(6, 6, 6));
        step();
        chk("ntk_we", oRAMWriteEnable, 0);
        chk("ntk_jump", oJumpFlag, 0);

        // underflow is sticky until reset
        drive(0, 16'h0, 16'h0, 16'h80, 16'h81, 1, 0, 0, row(4, 4, 4));
        step();
        idle();
        step();
        chk("uf_set", oUnderflow, 1);
        do_reset();
        step();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 3);
            op = (r == 0) ? 16'h0 : (r == 1) ? 16'hB000 | 16'($urandom_range(0, 4095))
                                             : 16'h1000 | 16'($urandom_range(0, 4095));
            r = $urandom_range(0, 7);
            drive($urandom_range(0, 1) == 1, op, 16'(16'h10 + $urandom_range(0, 7)),
                  16'(16'h10 + $urandom_range(0, 11)), 16'(16'h10 + $urandom_range(0, 11)),
                  $urandom_range(0, 2) == 0, r == 0, r == 1,
                  {$urandom, $urandom, $urandom});
            step();
            if (n == 700) begin
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
